// File: rtl/credit_pkg.sv
// Shared types and defaults for the credit return scheduler.
package credit_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_INIT_HOLD = 8;
  localparam int HOLD_W        = 8;

  // Largest count a default-width pending counter can hold before it saturates.
  localparam logic [DEF_CNT_W-1:0] PEND_MAX = '1;

  typedef logic [DEF_CNT_W-1:0]             pend_t;
  typedef logic [$clog2(DEF_NUM_REQ)-1:0]   gid_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_return_scheduler.sv
// Accumulates per-consumer credit releases and returns them one per cycle,
// round-robin, on the receiver's pop_credit strobe; owns credit_withhold.
module credit_return_scheduler
  import credit_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int INIT_HOLD = DEF_INIT_HOLD,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_release,
  output logic [NUM_REQ-1:0] req_full,
  output logic [NUM_REQ-1:0] overflow_err,
  input  logic               receiver_in_reset,
  input  logic               cfg_withhold,
  output logic               pop_credit,
  output logic               credit_withhold,
  output logic [IDX_W-1:0]   grant_id,
  output logic               pending_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   pending [NUM_REQ];
  logic [NUM_REQ-1:0] nonzero;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [IDX_W-1:0]   rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               drain_en;

  assign drain_en = (hold_cnt == '0) && !cfg_withhold && !receiver_in_reset;

  always_comb begin
    nonzero  = '0;
    req_full = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nonzero[i]  = (pending[i] != '0);
      req_full[i] = (pending[i] == CNT_MAX);
    end
  end

  assign pending_any = |nonzero;
  assign arb_req     = nonzero & {NUM_REQ{drain_en}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .gnt   (gnt_oh),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt        <= HOLD_W'(INIT_HOLD);
      pop_credit      <= 1'b0;
      grant_id        <= '0;
      credit_withhold <= 1'b1;
      rr_ptr          <= '0;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
      pop_credit      <= gnt_valid;
      credit_withhold <= !drain_en;
      if (gnt_valid) begin
        grant_id <= gnt_idx;
        rr_ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // A release on a full counter is still accepted when that counter is granted.
    assign dec = gnt_oh[g];
    assign inc = req_release[g] && (!req_full[g] || dec);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (inc && !dec)      cnt <= cnt + CNT_W'(1);
        else if (dec && !inc) cnt <= cnt - CNT_W'(1);
        if (req_release[g] && !inc) ovf <= 1'b1;
      end
    end

    assign pending[g]      = cnt;
    assign overflow_err[g] = ovf;
  end

endmodule

// File: tb/tb_credit_return_scheduler.sv
// Directed bench for credit_return_scheduler with an expected-grant queue.
module tb_credit_return_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req_release;
  logic [3:0] req_full;
  logic [3:0] overflow_err;
  logic       receiver_in_reset;
  logic       cfg_withhold;
  logic       pop_credit;
  logic       credit_withhold;
  logic [1:0] grant_id;
  logic       pending_any;

  logic [1:0] exp_q[$];
  int errors;
  int checks;

  credit_return_scheduler #(.NUM_REQ(4), .CNT_W(4), .INIT_HOLD(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_release       (req_release),
    .req_full          (req_full),
    .overflow_err      (overflow_err),
    .receiver_in_reset (receiver_in_reset),
    .cfg_withhold      (cfg_withhold),
    .pop_credit        (pop_credit),
    .credit_withhold   (credit_withhold),
    .grant_id          (grant_id),
    .pending_any       (pending_any)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample 1ns after the edge, score any pop
  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_credit === 1'b1) begin
      chk("sb_pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_grant_id", 32'(grant_id), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic expect_pops(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("pop_burst", 32'(pop_credit), 32'd1);
    end
  endtask

  task automatic push_n(input logic [1:0] id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(id);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    req_release = '0;
    receiver_in_reset = 1'b0;
    cfg_withhold = 1'b0;

    // reset values
    repeat (3) tick();
    chk("rst_pop", 32'(pop_credit), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_withhold", 32'(credit_withhold), 32'd1);
    chk("rst_full", 32'(req_full), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    chk("rst_pending_any", 32'(pending_any), 32'd0);

    // reset hold: one release at cycle 1, pop at cycle 9
    rst = 1'b1;
    req_release = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      req_release = '0;
      chk("hold_no_pop", 32'(pop_credit), 32'd0);
      chk("hold_withhold", 32'(credit_withhold), 32'd1);
    end
    push_n(2'd0, 1);
    tick();
    chk("hold_first_pop", 32'(pop_credit), 32'd1);
    chk("hold_withhold_drop", 32'(credit_withhold), 32'd0);
    chk("hold_pending_any", 32'(pending_any), 32'd0);

    // round robin: pointer sits at 1 after the first grant
    req_release = 4'b1110;
    push_n(2'd1, 1); push_n(2'd2, 1); push_n(2'd3, 1);
    tick();
    req_release = '0;
    chk("rr_latency_no_pop", 32'(pop_credit), 32'd0);
    expect_pops(3);
    req_release = 4'b1111;
    push_n(2'd0, 1); push_n(2'd1, 1); push_n(2'd2, 1); push_n(2'd3, 1);
    tick();
    req_release = '0;
    expect_pops(3);
    chk("rr_pending_any_before_last", 32'(pending_any), 32'd1);
    expect_pops(1);
    chk("rr_pending_any_after", 32'(pending_any), 32'd0);
    tick();
    chk("rr_idle", 32'(pop_credit), 32'd0);
    chk("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // saturation under software withhold
    cfg_withhold = 1'b1;
    req_release = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("sat_no_pop", 32'(pop_credit), 32'd0);
    end
    req_release = '0;
    chk("sat_withhold", 32'(credit_withhold), 32'd1);
    chk("sat_full", 32'(req_full), 32'b0100);
    chk("sat_ovf", 32'(overflow_err), 32'b0100);
    cfg_withhold = 1'b0;
    push_n(2'd2, 15);
    expect_pops(1);
    chk("sat_full_clears", 32'(req_full), 32'd0);
    expect_pops(14);
    tick();
    chk("sat_exactly_15", 32'(pop_credit), 32'd0);
    chk("sat_pending_any", 32'(pending_any), 32'd0);

    // simultaneous increment and grant on a full counter
    cfg_withhold = 1'b1;
    req_release = 4'b0010;
    repeat (15) tick();
    chk("sim_full", 32'(req_full), 32'b0010);
    chk("sim_no_ovf_fill", 32'(overflow_err[1]), 32'd0);
    cfg_withhold = 1'b0;
    push_n(2'd1, 6);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sim_pop", 32'(pop_credit), 32'd1);
      chk("sim_stays_full", 32'(req_full[1]), 32'd1);
      chk("sim_no_ovf", 32'(overflow_err[1]), 32'd0);
    end
    req_release = '0;
    push_n(2'd1, 15);
    expect_pops(15);
    tick();
    chk("sim_drained", 32'(pop_credit), 32'd0);
    chk("sim_ovf_vec", 32'(overflow_err), 32'b0100);

    // receiver reset mid-drain with 3 credits left
    cfg_withhold = 1'b1;
    req_release = 4'b1000;
    repeat (5) tick();
    req_release = '0;
    cfg_withhold = 1'b0;
    push_n(2'd3, 2);
    expect_pops(2);
    receiver_in_reset = 1'b1;
    req_release = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_release = '0;
      chk("rx_rst_no_pop", 32'(pop_credit), 32'd0);
      chk("rx_rst_withhold", 32'(credit_withhold), 32'd1);
      chk("rx_rst_retained", 32'(pending_any), 32'd1);
    end
    push_n(2'd0, 1);
    push_n(2'd3, 3);
    receiver_in_reset = 1'b0;
    expect_pops(4);
    tick();
    chk("rx_rst_done", 32'(pop_credit), 32'd0);
    chk("rx_rst_withhold_low", 32'(credit_withhold), 32'd0);
    chk("rx_rst_pending_any", 32'(pending_any), 32'd0);

    // asynchronous reset mid-drain
    cfg_withhold = 1'b1;
    req_release = 4'b0101;
    repeat (3) tick();
    req_release = '0;
    cfg_withhold = 1'b0;
    push_n(2'd0, 1);
    push_n(2'd2, 1);
    expect_pops(2);
    chk("arst_queue_empty", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    #2;
    chk("arst_pop", 32'(pop_credit), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd0);
    chk("arst_withhold", 32'(credit_withhold), 32'd1);
    chk("arst_full", 32'(req_full), 32'd0);
    chk("arst_ovf", 32'(overflow_err), 32'd0);
    chk("arst_pending_any", 32'(pending_any), 32'd0);
    exp_q.delete();
    tick();
    chk("arst_held_pop", 32'(pop_credit), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
